// File: rtl/mux_arb_pkg.sv
// Shared types and sizing for the round-robin 4:1 mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int SEL_W  = 2;
  localparam int HOLD_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching start, start+1, ... (mod 4).
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] index
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    found = 1'b0;
    index = start;
    cand  = start;
    for (int k = 0; k < N_REQ; k++) begin
      cand = start + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux with bounded hold time; drives only sel/en of the mux.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             busy
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [N_REQ-1:0] cand_req;
  logic [SEL_W-1:0] start;
  logic             found;
  logic [SEL_W-1:0] index;
  logic             hold_full;
  logic             take_new;
  logic             go_idle;

  // While granting, sel is the current holder; it is masked out so only other requesters compete.
  always_comb begin
    cand_req = req;
    start    = ptr;
    if (state == GRANT) begin
      cand_req = req & ~onehot(sel);
      start    = sel + SEL_W'(1);
    end
  end

  rr_pick u_pick (
    .req   (cand_req),
    .start (start),
    .found (found),
    .index (index)
  );

  assign hold_full = (hold_cnt >= HOLD_MAX);

  always_comb begin
    take_new = 1'b0;
    go_idle  = 1'b0;
    if (state == IDLE) begin
      take_new = found;
    end else if (!req[sel]) begin
      take_new = found;
      go_idle  = !found;
    end else if (hold_full) begin
      take_new = found;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      en       <= 1'b0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else if (take_new) begin
      state    <= GRANT;
      gnt      <= onehot(index);
      sel      <= index;
      en       <= 1'b1;
      busy     <= 1'b1;
      ptr      <= index + SEL_W'(1);
      hold_cnt <= HOLD_W'(1);
    end else if (go_idle) begin
      // sel deliberately keeps the last holder so the mux select stays stable while disabled
      state    <= IDLE;
      gnt      <= '0;
      en       <= 1'b0;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else if (state == GRANT && !hold_full) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: MAX_HOLD=4 main instance plus a MAX_HOLD=1 instance.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt, gnt1;
  logic [1:0] sel, sel1;
  logic       en, en1, busy, busy1;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en;
    logic       busy;
  } obs_t;

  typedef struct {
    bit active;
    int cur;
    int ptr;
    int hold;
  } m_t;

  obs_t q[$];
  obs_t q1[$];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk), .rst (rst), .req (req),
    .gnt (gnt), .sel (sel), .en (en), .busy (busy)
  );

  mux_rr_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk (clk), .rst (rst), .req (req),
    .gnt (gnt1), .sel (sel1), .en (en1), .busy (busy1)
  );

  function automatic obs_t g(input int idx);
    obs_t o;
    o.gnt  = 4'b0001 << idx;
    o.sel  = 2'(idx);
    o.en   = 1'b1;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t idle(input int s);
    obs_t o;
    o.gnt  = 4'b0000;
    o.sel  = 2'(s);
    o.en   = 1'b0;
    o.busy = 1'b0;
    return o;
  endfunction

  // Reference model written straight from the arbitration rules.
  function automatic m_t model_next(input m_t m, input logic [3:0] r, input logic rs, input int maxh);
    m_t n;
    logic [3:0] cand;
    int start;
    int idx;
    bit found;
    n = m;
    if (rs) begin
      n.active = 1'b0; n.cur = 0; n.ptr = 0; n.hold = 0;
      return n;
    end
    cand = r;
    start = m.ptr;
    if (m.active) begin
      cand[m.cur] = 1'b0;
      start = (m.cur + 1) % 4;
    end
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      if (!found && cand[(start + k) % 4]) begin
        found = 1'b1;
        idx = (start + k) % 4;
      end
    end
    if (!m.active || !r[m.cur] || m.hold >= maxh) begin
      if (found) begin
        n.active = 1'b1; n.cur = idx; n.ptr = (idx + 1) % 4; n.hold = 1;
      end else if (m.active && !r[m.cur]) begin
        n.active = 1'b0; n.hold = 0;
      end
    end else begin
      n.hold = m.hold + 1;
    end
    return n;
  endfunction

  function automatic obs_t obs_of(input m_t m);
    return m.active ? g(m.cur) : idle(m.cur);
  endfunction

  task automatic tick(input logic [3:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
    @(posedge clk);
    #1;
  endtask

  // Structural invariants on both instances every cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      checks += 2;
      if ((gnt & (gnt - 4'd1)) != 4'd0 || en !== (|gnt) || busy !== en || (en && !gnt[sel])) begin
        errors++;
        $display("FAIL invariant dut: gnt=%b sel=%0d en=%b busy=%b", gnt, sel, en, busy);
      end
      if ((gnt1 & (gnt1 - 4'd1)) != 4'd0 || en1 !== (|gnt1) || busy1 !== en1 || (en1 && !gnt1[sel1])) begin
        errors++;
        $display("FAIL invariant dut1: gnt=%b sel=%0d en=%b busy=%b", gnt1, sel1, en1, busy1);
      end
    end
  end

  task automatic test_reset();
    obs_t o;
    for (int i = 0; i < 2; i++) begin
      q.push_back(idle(0));
      tick(4'b1111, 1'b1);
      o = q.pop_front();
      checks++;
      if ({gnt, sel, en, busy} !== o) begin
        errors++;
        $display("FAIL reset[%0d]: got gnt=%b sel=%0d en=%b busy=%b want gnt=%b sel=%0d en=%b busy=%b",
                 i, gnt, sel, en, busy, o.gnt, o.sel, o.en, o.busy);
      end
    end
    mon_on = 1'b1;
  endtask

  task automatic test_first_grant();
    logic [3:0] stim [2];
    obs_t o;
    stim[0] = 4'b0001; stim[1] = 4'b0000;
    q.push_back(g(0));
    q.push_back(idle(0));
    tick(4'b0000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick(stim[i], 1'b0);
      o = q.pop_front();
      checks++;
      if ({gnt, sel, en, busy} !== o) begin
        errors++;
        $display("FAIL first_grant[%0d]: got gnt=%b sel=%0d en=%b busy=%b want gnt=%b sel=%0d en=%b busy=%b",
                 i, gnt, sel, en, busy, o.gnt, o.sel, o.en, o.busy);
      end
    end
  endtask

  task automatic test_rotation();
    obs_t o;
    tick(4'b0000, 1'b1);
    for (int i = 0; i < 17; i++) q.push_back(g((i / 4) % 4));
    for (int i = 0; i < 17; i++) begin
      tick(4'b1111, 1'b0);
      o = q.pop_front();
      checks++;
      if ({gnt, sel, en, busy} !== o) begin
        errors++;
        $display("FAIL rotation[%0d]: got gnt=%b sel=%0d want gnt=%b sel=%0d", i, gnt, sel, o.gnt, o.sel);
      end
    end
  endtask

  task automatic test_late_preempt();
    obs_t o;
    tick(4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) q.push_back(g(0));
    q.push_back(g(2));
    for (int i = 0; i < 11; i++) begin
      tick((i < 10) ? 4'b0001 : 4'b0101, 1'b0);
      o = q.pop_front();
      checks++;
      if ({gnt, sel, en, busy} !== o) begin
        errors++;
        $display("FAIL late_preempt[%0d]: got gnt=%b sel=%0d want gnt=%b sel=%0d", i, gnt, sel, o.gnt, o.sel);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] stim [6];
    obs_t o;
    stim = '{4'b0010, 4'b0000, 4'b0011, 4'b0010, 4'b0110, 4'b0100};
    q.push_back(g(1)); q.push_back(idle(1)); q.push_back(g(2 - 2));
    q.push_back(g(1)); q.push_back(g(1));   q.push_back(g(2));
    tick(4'b0000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(stim[i], 1'b0);
      o = q.pop_front();
      checks++;
      if ({gnt, sel, en, busy} !== o) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got gnt=%b sel=%0d en=%b busy=%b want gnt=%b sel=%0d en=%b busy=%b",
                 i, gnt, sel, en, busy, o.gnt, o.sel, o.en, o.busy);
      end
    end
  endtask

  task automatic test_rst_mid_grant();
    obs_t o;
    for (int v = 0; v < 2; v++) begin
      tick(4'b0000, 1'b1);
      q.push_back(g(v == 0 ? 3 : 2));
      q.push_back(idle(0));
      q.push_back(g(0));
      for (int i = 0; i < 3; i++) begin
        if (i == 0) tick(v == 0 ? 4'b1000 : 4'b0100, 1'b0);
        else        tick(4'b1111, i == 1);
        o = q.pop_front();
        checks++;
        if ({gnt, sel, en, busy} !== o) begin
          errors++;
          $display("FAIL rst_mid[%0d.%0d]: got gnt=%b sel=%0d en=%b want gnt=%b sel=%0d en=%b",
                   v, i, gnt, sel, en, o.gnt, o.sel, o.en);
        end
      end
    end
  endtask

  task automatic test_max_hold1();
    logic [3:0] stim [8];
    int exp_idx [8];
    obs_t o;
    stim    = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0101, 4'b0101, 4'b0101};
    exp_idx = '{0, 1, 2, 3, 0, 2, 0, 2};
    tick(4'b0000, 1'b1);
    for (int i = 0; i < 8; i++) q1.push_back(g(exp_idx[i]));
    for (int i = 0; i < 8; i++) begin
      tick(stim[i], 1'b0);
      o = q1.pop_front();
      checks++;
      if ({gnt1, sel1, en1, busy1} !== o) begin
        errors++;
        $display("FAIL max_hold1[%0d]: got gnt=%b sel=%0d want gnt=%b sel=%0d", i, gnt1, sel1, o.gnt, o.sel);
      end
    end
  endtask

  task automatic test_random();
    m_t m, m1;
    obs_t o, o1;
    logic [3:0] r;
    logic rs;
    m  = model_next('{0, 0, 0, 0}, 4'b0000, 1'b1, 4);
    m1 = model_next('{0, 0, 0, 0}, 4'b0000, 1'b1, 1);
    tick(4'b0000, 1'b1);
    for (int i = 0; i < 400; i++) begin
      r  = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 39) == 0);
      m  = model_next(m, r, rs, 4);
      m1 = model_next(m1, r, rs, 1);
      q.push_back(obs_of(m));
      q1.push_back(obs_of(m1));
      tick(r, rs);
      if (q.size() == 0 || q1.size() == 0) begin
        errors++;
        $display("FAIL random[%0d]: scoreboard empty", i);
      end else begin
        o  = q.pop_front();
        o1 = q1.pop_front();
        checks += 2;
        if ({gnt, sel, en, busy} !== o) begin
          errors++;
          $display("FAIL random[%0d] dut: req=%b got gnt=%b sel=%0d en=%b want gnt=%b sel=%0d en=%b",
                   i, r, gnt, sel, en, o.gnt, o.sel, o.en);
        end
        if ({gnt1, sel1, en1, busy1} !== o1) begin
          errors++;
          $display("FAIL random[%0d] dut1: req=%b got gnt=%b sel=%0d en=%b want gnt=%b sel=%0d en=%b",
                   i, r, gnt1, sel1, en1, o1.gnt, o1.sel, o1.en);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_rotation();
    test_late_preempt();
    test_back_to_back();
    test_rst_mid_grant();
    test_max_hold1();
    test_random();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, meaning the maximum consecutive grant cycles before preemption when another requester waits (legal range 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester request for the shared 4:1 mux; bit i = requester i (mux input a,b,c,d for i=0..3).
REQ-005 Port: gnt  output  4  one-hot grant; all-zero when no grant.
REQ-006 Port: sel  output  2  mux select; equals the index of the set gnt bit.
REQ-007 Port: en  output  1  mux enable; high exactly when gnt is non-zero.
REQ-008 Port: busy  output  1  high while in state GRANT.

Function
REQ-009 All outputs SHALL be registered; none SHALL depend combinationally on req.
REQ-010 The block SHALL implement two states: IDLE (gnt=0, en=0) and GRANT (exactly one gnt bit set, en=1).
REQ-011 Selection SHALL be round-robin: search order ptr, ptr+1, ptr+2, ptr+3 (mod 4), first set req bit wins.
REQ-012 IDLE -> GRANT: req sampled non-zero at edge t -> gnt/sel/en valid from cycle t+1; hold_cnt set to 1.
REQ-013 In GRANT, req[cur] sampled low -> next cycle grants the winner searched from cur+1 if any other req set (hold_cnt=1), else returns to IDLE.
REQ-014 In GRANT, req[cur] high and hold_cnt < MAX_HOLD -> grant retained, hold_cnt increments.
REQ-015 In GRANT, req[cur] high, hold_cnt == MAX_HOLD, another req bit set -> grant moves to the winner searched from cur+1 next cycle (preemption), hold_cnt=1.
REQ-016 In GRANT, hold_cnt == MAX_HOLD, no other req -> grant retained, hold_cnt saturates at MAX_HOLD (so preemption happens the first cycle another requester appears).
REQ-017 ptr SHALL update to (new grant index + 1) mod 4 on every new grant.
REQ-018 A grant handover SHALL NOT insert an idle cycle: gnt goes directly from old one-hot to new one-hot.
REQ-019 sel SHALL hold its last value while en=0 (after reset: 0).
REQ-020 MAX_HOLD=1 SHALL give strict per-cycle rotation among all active requesters.

Reset
REQ-021 On rst sampled high: state=IDLE, gnt=0, sel=0, en=0, busy=0, ptr=0, hold_cnt=0, at the next edge regardless of state.
REQ-022 rst mid-grant SHALL drop gnt/en the cycle after assertion; req ignored while rst high; first grant after rst release uses ptr=0.

Structure
REQ-023 Package mux_arb_pkg SHALL hold the state enum (IDLE, GRANT), N_REQ=4, SEL_W=2 and HOLD_W=4.
REQ-024 Sub-module rr_pick SHALL be the combinational picker: inputs req[3:0], start index; outputs found, index[1:0].
REQ-025 Top SHALL drive the existing mux via sel/en only; no data path through the arbiter.

Verification
REQ-026 Reset then req=0001 at cycle 1 -> cycle 2 gnt=0001, sel=0, en=1, busy=1.
REQ-027 req=1111 held, MAX_HOLD=4 -> grants 0001x4, 0010x4, 0100x4, 1000x4, then 0001 again; no gaps.
REQ-028 Holder 0 only, req=0001 for 10 cycles, then req=0101 -> gnt moves to 0100 the cycle after req[2] sampled.
REQ-029 gnt=0010, req drops to 0000 -> next cycle gnt=0000, en=0, sel stays 1, busy=0.
REQ-030 gnt=1000, rst pulsed one cycle with req=1111 -> gnt=0000 cycle after rst, then gnt=0001 (ptr=0).
REQ-031 Assertion throughout: gnt one-hot or zero, en==|gnt, sel==index(gnt) when en.
